// File: rtl/mult_pack_normalise_if.sv
// Bundle interface for the multiply pack/normalise stage.
// The master drives the arithmetic/special bundle and reads back the packed result;
// the slave is the pipeline itself.
interface mult_pack_normalise_if #(
    parameter int EXP_W = 10
);
    logic             valid_in;
    logic             idle_in;
    logic [31:0]      bypass_in;
    logic             z_sign;
    logic [EXP_W-1:0] z_exponent;
    logic [47:0]      z_product;
    logic [7:0]       InsTag_in;
    logic [31:0]      z_out;
    logic             valid_out;
    logic [7:0]       InsTag_out;

    modport master (
        output valid_in, idle_in, bypass_in, z_sign, z_exponent, z_product, InsTag_in,
        input  z_out, valid_out, InsTag_out
    );

    modport slave (
        input  valid_in, idle_in, bypass_in, z_sign, z_exponent, z_product, InsTag_in,
        output z_out, valid_out, InsTag_out
    );
endinterface

// File: rtl/mult_pack_normalise.sv
// Back end of the floating-point multiply datapath: normalise the 48-bit
// mantissa product, denormalise small results, round to nearest-even and pack
// an IEEE-754 single. Three-stage fixed-latency pipeline, no backpressure.
// Special results from the unpack stage (idle flag) bypass all arithmetic.
module mult_pack_normalise #(
    parameter int EXP_W = 10
) (
    input  logic                  clock,
    input  logic                  reset,
    mult_pack_normalise_if.slave  bus
);
    localparam int LATENCY = 3;
    // One extra bit of headroom so exponent+1 never wraps.
    localparam int XW = EXP_W + 1;
    localparam logic signed [XW-1:0] EXP_MIN   = XW'(-126);
    localparam logic signed [XW-1:0] EXP_MAX   = XW'(127);
    localparam logic signed [XW-1:0] SHIFT_SAT = XW'(26);

    // ---------------------------------------------------------------
    // Valid/tag delay line shared by stages 1..LATENCY-1
    // ---------------------------------------------------------------
    logic [LATENCY-2:0] valid_pipe_reg;
    logic [LATENCY-2:0] valid_pipe_next;
    logic [7:0]         tag_pipe_reg  [LATENCY-1];
    logic [7:0]         tag_pipe_next [LATENCY-1];

    genvar gi;
    generate
        for (gi = 0; gi < LATENCY - 1; gi++) begin : g_meta
            if (gi == 0) begin : g_head
                assign valid_pipe_next[gi] = bus.valid_in;
                assign tag_pipe_next[gi]   = bus.InsTag_in;
            end else begin : g_body
                assign valid_pipe_next[gi] = valid_pipe_reg[gi-1];
                assign tag_pipe_next[gi]   = tag_pipe_reg[gi-1];
            end
        end
    endgenerate

    // Valid bits are cleared by reset so in-flight bundles never emerge.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_pipe_reg <= '0;
        end else begin
            valid_pipe_reg <= valid_pipe_next;
        end
    end

    // Tags simply follow their bundle; stale values under valid=0 are harmless.
    always_ff @(posedge clock) begin
        tag_pipe_reg <= tag_pipe_next;
    end

    // ---------------------------------------------------------------
    // Stage 1: normalise on the product MSB
    // ---------------------------------------------------------------
    logic                 p47;
    logic [23:0]          mant1_next;
    logic                 guard1_next;
    logic                 round1_next;
    logic                 sticky1_next;
    logic signed [XW-1:0] exp1_next;
    logic                 zero1_next;

    // Pick the 24-bit window and its guard/round/sticky tail.
    always_comb begin
        p47          = bus.z_product[47];
        mant1_next   = p47 ? bus.z_product[47:24] : bus.z_product[46:23];
        guard1_next  = p47 ? bus.z_product[23] : bus.z_product[22];
        round1_next  = p47 ? bus.z_product[22] : bus.z_product[21];
        sticky1_next = p47 ? (|bus.z_product[21:0]) : (|bus.z_product[20:0]);
        exp1_next    = $signed({bus.z_exponent[EXP_W-1], bus.z_exponent})
                       + (p47 ? XW'(1) : XW'(0));
        zero1_next   = (bus.z_product == 48'd0);
    end

    logic [23:0]          mant1_reg;
    logic                 guard1_reg, round1_reg, sticky1_reg;
    logic signed [XW-1:0] exp1_reg;
    logic                 zero1_reg, sign1_reg, idle1_reg;
    logic [31:0]          bypass1_reg;

    // Stage 1 data register.
    always_ff @(posedge clock) begin
        mant1_reg   <= mant1_next;
        guard1_reg  <= guard1_next;
        round1_reg  <= round1_next;
        sticky1_reg <= sticky1_next;
        exp1_reg    <= exp1_next;
        zero1_reg   <= zero1_next;
        sign1_reg   <= bus.z_sign;
        idle1_reg   <= bus.idle_in;
        bypass1_reg <= bus.bypass_in;
    end

    // ---------------------------------------------------------------
    // Stage 2: denormalise results below the smallest normal exponent
    // ---------------------------------------------------------------
    logic signed [XW-1:0] shift_full;
    logic [4:0]           shift_amt;
    logic [51:0]          denorm_vec;
    logic [23:0]          mant2_next;
    logic                 guard2_next, round2_next, sticky2_next;
    logic signed [XW-1:0] exp2_next;

    // Shift {mant,guard,round} right; everything falling off joins sticky.
    always_comb begin
        shift_full   = EXP_MIN - exp1_reg;
        shift_amt    = (shift_full > SHIFT_SAT) ? 5'd26 : shift_full[4:0];
        denorm_vec   = {mant1_reg, guard1_reg, round1_reg, 26'd0} >> shift_amt;
        mant2_next   = mant1_reg;
        guard2_next  = guard1_reg;
        round2_next  = round1_reg;
        sticky2_next = sticky1_reg;
        exp2_next    = exp1_reg;
        if (exp1_reg < EXP_MIN) begin
            mant2_next   = denorm_vec[51:28];
            guard2_next  = denorm_vec[27];
            round2_next  = denorm_vec[26];
            sticky2_next = sticky1_reg | (|denorm_vec[25:0]);
            exp2_next    = EXP_MIN;
        end
    end

    logic [23:0]          mant2_reg;
    logic                 guard2_reg, round2_reg, sticky2_reg;
    logic signed [XW-1:0] exp2_reg;
    logic                 zero2_reg, sign2_reg, idle2_reg;
    logic [31:0]          bypass2_reg;

    // Stage 2 data register.
    always_ff @(posedge clock) begin
        mant2_reg   <= mant2_next;
        guard2_reg  <= guard2_next;
        round2_reg  <= round2_next;
        sticky2_reg <= sticky2_next;
        exp2_reg    <= exp2_next;
        zero2_reg   <= zero1_reg;
        sign2_reg   <= sign1_reg;
        idle2_reg   <= idle1_reg;
        bypass2_reg <= bypass1_reg;
    end

    // ---------------------------------------------------------------
    // Stage 3: round to nearest-even and pack
    // ---------------------------------------------------------------
    logic                 round_inc;
    logic [24:0]          mant_sum;
    logic [23:0]          mant3;
    logic signed [XW-1:0] exp3;
    logic [7:0]           exp3_biased;
    logic [31:0]          result;

    // Rounding carry can overflow into bit 24, which bumps the exponent.
    always_comb begin
        round_inc   = guard2_reg & (round2_reg | sticky2_reg | mant2_reg[0]);
        mant_sum    = {1'b0, mant2_reg} + {24'd0, round_inc};
        mant3       = mant_sum[23:0];
        exp3        = exp2_reg;
        if (mant_sum[24]) begin
            mant3 = mant_sum[24:1];
            exp3  = exp2_reg + XW'(1);
        end
        exp3_biased = exp3[7:0] + 8'd127;
        if (idle2_reg) begin
            result = bypass2_reg;
        end else if (zero2_reg) begin
            result = {sign2_reg, 31'd0};
        end else if (exp3 > EXP_MAX) begin
            result = {sign2_reg, 8'hFF, 23'd0};
        end else if ((exp3 == EXP_MIN) && !mant3[23]) begin
            result = {sign2_reg, 8'h00, mant3[22:0]};
        end else begin
            result = {sign2_reg, exp3_biased, mant3[22:0]};
        end
    end

    // Output register: updates only for a valid stage-3 bundle, else holds.
    always_ff @(posedge clock) begin
        if (reset) begin
            bus.valid_out  <= 1'b0;
            bus.z_out      <= 32'd0;
            bus.InsTag_out <= 8'd0;
        end else begin
            bus.valid_out <= valid_pipe_reg[LATENCY-2];
            if (valid_pipe_reg[LATENCY-2]) begin
                bus.z_out      <= result;
                bus.InsTag_out <= tag_pipe_reg[LATENCY-2];
            end
        end
    end
endmodule

// File: tb/tb_mult_pack_normalise.sv
// Testbench for mult_pack_normalise: directed cases plus randomized bundles
// checked against an exact rounding model of the product value.
module tb_mult_pack_normalise;
    logic clock;
    logic reset;
    int   n_cmp;
    int   n_bad;

    mult_pack_normalise_if #(.EXP_W(10)) bif ();

    mult_pack_normalise #(.EXP_W(10)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bif)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference: value = p * 2^(e-46); round that exactly to a single.
    function automatic logic [31:0] ref_model(input logic idle, input logic [31:0] byp,
                                              input logic s, input int e,
                                              input logic [47:0] p);
        int               ex, ee, k;
        longint unsigned  pv, q, rem, half;
        if (idle) return byp;
        if (p == 48'd0) return {s, 31'd0};
        ex = e + (p[47] ? 1 : 0);
        ee = (ex < -126) ? -126 : ex;
        k  = ee - e + 23;
        pv = {16'd0, p};
        if (k > 62) begin
            q = 0; rem = pv; half = 64'hFFFF_FFFF_FFFF_FFFF;
        end else begin
            q    = pv >> k;
            rem  = pv & ((64'd1 << k) - 1);
            half = 64'd1 << (k - 1);
        end
        if (rem > half || (rem == half && q[0])) q = q + 1;
        if (q >= (64'd1 << 24)) begin
            q  = q >> 1;
            ee = ee + 1;
        end
        if (ee > 127) return {s, 8'hFF, 23'd0};
        if (q < (64'd1 << 23)) return {s, 8'h00, q[22:0]};
        return {s, 8'(ee + 127), q[22:0]};
    endfunction

    // Scoreboard: one record per clock edge, the record three edges old emerges.
    typedef struct {
        logic        v;
        logic [31:0] z;
        logic [7:0]  tag;
    } rec_t;

    rec_t        hist[$];
    rec_t        cur;
    logic [31:0] cur_exp;
    logic        started;
    logic        exp_v;
    logic [31:0] held_z;
    logic [7:0]  held_tag;

    initial begin
        started  = 1'b0;
        exp_v    = 1'b0;
        held_z   = 32'd0;
        held_tag = 8'd0;
    end

    // Record what the DUT samples this edge and derive the expected output state.
    always @(posedge clock) begin
        cur.v   = bif.valid_in && !reset;
        cur.z   = cur_exp;
        cur.tag = bif.InsTag_in;
        hist.push_back(cur);
        if (hist.size() > 3) void'(hist.pop_front());
        if (reset) begin
            foreach (hist[i]) hist[i].v = 1'b0;
            held_z   = 32'd0;
            held_tag = 8'd0;
            started  = 1'b1;
        end
        exp_v = 1'b0;
        if (hist.size() == 3 && hist[0].v) begin
            exp_v    = 1'b1;
            held_z   = hist[0].z;
            held_tag = hist[0].tag;
        end
    end

    // Compare outputs mid-cycle, one line per valid transaction.
    always @(negedge clock) begin
        if (started) begin
            n_cmp++;
            assert (bif.valid_out === exp_v) else begin
                n_bad++;
                $error("FAIL valid_out: observed %b expected %b", bif.valid_out, exp_v);
            end
            n_cmp++;
            assert (bif.z_out === held_z) else begin
                n_bad++;
                $error("FAIL z_out: observed %h expected %h", bif.z_out, held_z);
            end
            n_cmp++;
            assert (bif.InsTag_out === held_tag) else begin
                n_bad++;
                $error("FAIL InsTag_out: observed %h expected %h", bif.InsTag_out, held_tag);
            end
            if (exp_v)
                $display("txn t=%0t tag=%h z_out=%h expected=%h", $time,
                         bif.InsTag_out, bif.z_out, held_z);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_cycle();
        bif.valid_in = 1'b0;
        cur_exp      = 32'd0;
        tick();
    endtask

    task automatic send(input logic idle, input logic [31:0] byp, input logic s,
                        input int e, input logic [47:0] p, input logic [7:0] tag,
                        input logic [31:0] expz);
        bif.valid_in   = 1'b1;
        bif.idle_in    = idle;
        bif.bypass_in  = byp;
        bif.z_sign     = s;
        bif.z_exponent = 10'(e);
        bif.z_product  = p;
        bif.InsTag_in  = tag;
        cur_exp        = expz;
        tick();
    endtask

    task automatic send_rand();
        logic            v, idle, s;
        logic [31:0]     byp;
        int              e;
        longint unsigned a, b;
        logic [47:0]     p;
        v    = ($urandom_range(0, 3) != 0);
        idle = ($urandom_range(0, 7) == 0);
        s    = 1'($urandom_range(0, 1));
        byp  = $urandom;
        case ($urandom_range(0, 4))
            0: e = $urandom_range(0, 200) - 100;
            1: e = $urandom_range(115, 135);
            2: e = -$urandom_range(120, 155);
            3: e = $urandom_range(0, 1023) - 512;
            default: e = $urandom_range(0, 3) - 128;
        endcase
        a = (64'd1 << 23) | 64'($urandom_range(0, (1 << 23) - 1));
        b = (64'd1 << 23) | 64'($urandom_range(0, (1 << 23) - 1));
        p = 48'(a * b);
        case ($urandom_range(0, 5))
            0: p = {p[47:22], 22'd0};
            1: p = {p[47:23], 1'b1, 22'd0};
            2: p = {p[47:24], 1'b1, 23'd0};
            3: if ($urandom_range(0, 3) == 0) p = 48'd0;
            default: ;
        endcase
        if (v) send(idle, byp, s, e, p, 8'($urandom), ref_model(idle, byp, s, e, p));
        else   idle_cycle();
    endtask

    initial begin
        n_cmp          = 0;
        n_bad          = 0;
        reset          = 1'b1;
        bif.valid_in   = 1'b0;
        bif.idle_in    = 1'b0;
        bif.bypass_in  = 32'd0;
        bif.z_sign     = 1'b0;
        bif.z_exponent = 10'd0;
        bif.z_product  = 48'd0;
        bif.InsTag_in  = 8'd0;
        cur_exp        = 32'd0;
        tick(); tick(); tick();
        reset = 1'b0;
        idle_cycle(); idle_cycle();

        // Directed cases with literal expected results.
        send(1'b0, 32'd0, 1'b0,    0, 48'h4000_0000_0000, 8'h11, 32'h3F80_0000);
        idle_cycle(); idle_cycle(); idle_cycle();
        send(1'b0, 32'd0, 1'b0,    0, 48'h9000_0000_0000, 8'h12, 32'h4010_0000);
        send(1'b0, 32'd0, 1'b0,    0, 48'h4000_0040_0000, 8'h13, 32'h3F80_0000);
        send(1'b0, 32'd0, 1'b0,    0, 48'h4000_00C0_0000, 8'h14, 32'h3F80_0002);
        send(1'b0, 32'd0, 1'b1,  127, 48'h8000_0000_0000, 8'h15, 32'hFF80_0000);
        send(1'b0, 32'd0, 1'b0, -127, 48'h4000_0000_0000, 8'h16, 32'h0040_0000);
        send(1'b0, 32'd0, 1'b0, -127, 48'h7FFF_FF80_0000, 8'h17, 32'h0080_0000);
        send(1'b0, 32'd0, 1'b1,  200, 48'h0000_0000_0000, 8'h18, 32'h8000_0000);
        send(1'b0, 32'd0, 1'b0, -400, 48'hFFFF_FFFF_FFFF, 8'h19, 32'h0000_0000);
        idle_cycle(); idle_cycle(); idle_cycle();

        // Bypass followed by two arithmetic bundles, back to back.
        send(1'b1, 32'hFFC0_0000, 1'b0, 0, 48'h4000_0000_0000, 8'h21, 32'hFFC0_0000);
        send(1'b0, 32'd0, 1'b0, 0, 48'h4000_0000_0000, 8'h22, 32'h3F80_0000);
        send(1'b0, 32'd0, 1'b0, 0, 48'h9000_0000_0000, 8'h23, 32'h4010_0000);
        idle_cycle(); idle_cycle(); idle_cycle(); idle_cycle();

        // Reset with two bundles in flight and a third offered during reset.
        send(1'b0, 32'd0, 1'b0, 0, 48'h4000_0000_0000, 8'h31, 32'h3F80_0000);
        send(1'b0, 32'd0, 1'b0, 0, 48'h9000_0000_0000, 8'h32, 32'h4010_0000);
        reset = 1'b1;
        send(1'b0, 32'd0, 1'b0, 0, 48'h4000_00C0_0000, 8'h33, 32'h3F80_0002);
        reset = 1'b0;
        idle_cycle(); idle_cycle(); idle_cycle();
        send(1'b0, 32'd0, 1'b1, 1, 48'h9000_0000_0000, 8'h34, 32'hC090_0000);
        idle_cycle(); idle_cycle(); idle_cycle();

        // Randomized streaming against the reference model.
        for (int i = 0; i < 600; i++) send_rand();
        for (int i = 0; i < 5; i++) idle_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mult_pack_normalise.md
Name: mult_pack_normalise

Overview:
- Back-end stage of the HCORDIC floating-point multiply datapath. It is the inverse of the special-case unpack stage.
- Takes the sign, signed unbiased exponent and 48-bit mantissa product, or an already-final special result flagged idle.
- Normalises, denormalises, rounds to nearest-even and packs an IEEE-754 single.
- 3-stage fixed-latency pipeline. Instruction tag and valid travel alongside the data.

Parameters:
- LATENCY, 3, pipeline depth in cycles; fixed, informational only, not configurable.
- EXP_W, 10, width of the signed unbiased exponent input.

Ports:
- clock  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- valid_in  in  1  input bundle valid this cycle.
- idle_in  in  1  1 = bypass_in is the final result (NaN/inf/zero from the special stage).
- bypass_in  in  32  packed special result, used when idle_in=1.
- z_sign  in  1  product sign.
- z_exponent  in  EXP_W  signed unbiased exponent, sum of the operand exponents.
- z_product  in  48  unsigned product of two 24-bit mantissas, hidden bits included.
- InsTag_in  in  8  instruction tag.
- z_out  out  32  packed IEEE-754 result.
- valid_out  out  1  z_out/InsTag_out valid.
- InsTag_out  out  8  tag aligned with z_out.

Behaviour:
- Reset (reset=1 at posedge):
  - All pipeline valid bits, valid_out, z_out and InsTag_out become 0.
  - Reset wins over a simultaneous valid_in. In-flight data is discarded; no output for it is ever produced.
- Pipeline:
  - No stall and no backpressure. Accepts one bundle every cycle.
  - valid_out is valid_in delayed by exactly 3 cycles. Tag and idle flag ride in lockstep.
  - Stage registers with valid=0 may hold stale data. z_out/InsTag_out update only when the stage-3 valid is 1; otherwise they hold their previous values.
- Stage 1, normalise:
  - If z_product[47]=1: mant=z_product[47:24], exp=z_exponent+1, guard=[23], round=[22], sticky=OR[21:0].
  - Else: mant=z_product[46:23], exp=z_exponent, guard=[22], round=[21], sticky=OR[20:0].
  - If z_product=0 and idle_in=0, force the zero path: result ±0 with sign=z_sign.
- Stage 2, denormalise:
  - If exp < -126: shift = -126-exp, saturated at 26. Right-shift {mant,guard,round} by shift; bits shifted out OR into sticky; exp=-126.
  - Otherwise pass through unchanged.
- Stage 3, round and pack:
  - Increment mant if guard & (round | sticky | mant[0]).
  - If the increment carries to bit 24: mant >>= 1, exp += 1.
  - If exp > 127: result {sign, 8'hFF, 23'd0} (infinity, no NaN generated here).
  - Else if exp == -126 and mant[23]=0: result {sign, 8'h00, mant[22:0]}, covering denormals and zero.
  - A denormal that rounds up into mant[23]=1 packs as exponent 1.
  - Else: result {sign, exp+127 (8 bits), mant[22:0]}.
- Idle bypass:
  - If the idle flag is set, z_out=bypass_in unmodified. All arithmetic is ignored.
  - The bypass still takes 3 cycles and keeps its tag.
- Widths:
  - Exponent arithmetic is carried in EXP_W+1 signed bits. There is no internal wrap; overflow is detected by the signed compare.
- Back-to-back: consecutive valid bundles emerge on consecutive cycles in order. No reordering and no bubbles are inserted.

Test Plan:
- 1.0×1.0: z_product=48'h4000_0000_0000, z_exponent=0, sign 0, tag 8'h11 -> 3 cycles later z_out=32'h3F80_0000, InsTag_out=8'h11, valid_out 1 for one cycle.
- 1.5×1.5 normalise shift: z_product=48'h9000_0000_0000, exp 0 -> z_out=32'h4010_0000.
- Round-to-even:
  - z_product=48'h4000_0040_0000 (exact tie, lsb even) -> 32'h3F80_0000.
  - z_product=48'h4000_00C0_0000 (tie, lsb odd) -> 32'h3F80_0002.
- Overflow and denormal:
  - exp=127, z_product=48'h8000_0000_0000, sign 1 -> 32'hFF80_0000.
  - exp=-127, z_product=48'h4000_0000_0000 -> 32'h0040_0000.
- Idle bypass plus streaming:
  - idle_in=1, bypass_in=32'hFFC0_0000, followed by two arithmetic bundles on the next two cycles -> outputs appear on 3 consecutive cycles in order.
  - The first output is 32'hFFC0_0000.
- Reset mid-flight: two bundles in the pipe, reset=1 for one cycle -> valid_out stays 0 for the following 3 cycles and z_out=0. The first post-reset input emerges with 3-cycle latency.
